fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader_pkg.sv | 23 ++
 rtl/fifo_burst_reader_beat_skid2.sv | 84 ++++++++
 rtl/fifo_burst_reader.sv | 147 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// ----------------------------------------------------------------------------
// fifo_burst_reader_pkg
// Shared definitions for the DDR3 controller burst read path:
//   - state_e           : burst reader FSM encoding (IDLE=0, BURST=1, PAD=2)
//   - BURST_LEN_DEFAULT : default number of beats per output burst
//   - cnt_width()       : width of the rd/beat counters for a given burst length
// ----------------------------------------------------------------------------
package fifo_burst_reader_pkg;

    localparam int unsigned BURST_LEN_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        PAD   = 2'd2
    } state_e;

    // One extra bit so a counter can hold BURST_LEN itself without wrapping.
    function automatic int unsigned cnt_width(input int unsigned burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_beat_skid2.sv
// ----------------------------------------------------------------------------
// beat_skid2
// Two-entry skid buffer holding words returned by the FIFO until the sink
// accepts them. The head entry is always the oldest word and drives the
// output directly from a register.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   push/push_data : write one word (ignored when full and not popping)
//   pop            : remove the head word (ignored when empty)
//   head_valid     : head entry holds a word
//   head_data      : head word
//   occupancy      : number of stored words (0..2)
// ----------------------------------------------------------------------------
module beat_skid2 #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  pop_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != 2'd0);
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = push_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop_ok) begin
                    // Head leaves and the new word takes its place.
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    count_d = 2'd2;
                end else if (pop_ok) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop_ok) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head_data  = head_q;
    assign occupancy  = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// fifo_burst_reader
// Pops words from a registered-read FIFO and presents them as fixed-length
// bursts of BURST_LEN beats on a valid/ready stream. A partial burst is closed
// with zero-data pad beats (out_mask=1) only while flush is held and the FIFO
// has run dry; otherwise the block waits for more data.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   fifo_empty_bar : FIFO holds at least one word
//   fifo_data      : FIFO read data, valid the cycle after fifo_re
//   fifo_re        : FIFO pop request
//   flush          : allow padding of a partial burst
//   out_valid/out_ready/out_data/out_mask/out_last : burst beat stream
//   busy           : FSM is not IDLE
// ----------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = BURST_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_empty_bar,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_re,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_mask,
    output logic                  out_last,
    output logic                  busy
);

    localparam int unsigned    CW        = cnt_width(BURST_LEN);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  BURST_CNT = CW'(BURST_LEN);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST_LEN - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                  inflight_q;

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [1:0]            skid_occ;
    logic                  skid_pop;
    logic                  xfer;
    logic [2:0]            fill_now;
    logic [2:0]            fill_limit;
    logic                  room_for_read;
    logic                  pad_start;

    beat_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (inflight_q),
        .push_data  (fifo_data),
        .pop        (skid_pop),
        .head_valid (skid_valid),
        .head_data  (skid_data),
        .occupancy  (skid_occ)
    );

    // Only the skid head can be valid outside PAD, and the skid is empty in PAD.
    assign out_valid = skid_valid || (state_q == PAD);
    assign out_data  = skid_valid ? skid_data : '0;
    assign out_mask  = (state_q == PAD);
    assign out_last  = out_valid && (beat_cnt_q == LAST_BEAT);
    assign busy      = (state_q != IDLE);

    assign xfer      = out_valid && out_ready;
    assign skid_pop  = skid_valid && out_ready;

    // A new read may be issued only if, counting the word still in flight and
    // the word leaving this cycle, the skid can still absorb it.
    // Written as "occ + inflight < 2 + pop" to avoid a subtraction.
    assign fill_now      = {1'b0, skid_occ} + {2'b00, inflight_q};
    assign fill_limit    = 3'd2 + {2'b00, skid_pop};
    assign room_for_read = (fill_now < fill_limit);

    assign fifo_re = (state_q == BURST) && fifo_empty_bar &&
                     (rd_cnt_q < BURST_CNT) && room_for_read;

    // Padding only once every fetched word has been delivered and the burst
    // is genuinely partial; a flush on an empty burst does nothing.
    assign pad_start = flush && !fifo_empty_bar && (skid_occ == 2'd0) &&
                       !inflight_q && (beat_cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (fifo_empty_bar) begin
                    state_d    = BURST;
                    rd_cnt_d   = '0;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (fifo_re) begin
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                end
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_ONE;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end else if (pad_start) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_ONE;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= fifo_re;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Drives fifo_burst_reader from a behavioural FIFO. Every word written to the
// FIFO also pushes its expected beat into a scoreboard, with burst position
// tracked as a plain modulo counter; pad beats are appended when a flush is
// requested on a partial burst. A negedge monitor pops and compares each
// accepted beat.
// ----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int DW = 16;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          fifo_empty_bar;
    logic [DW-1:0] fifo_data;
    logic          fifo_re;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_mask;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fifo_empty_bar (fifo_empty_bar),
        .fifo_data      (fifo_data),
        .fifo_re        (fifo_re),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_mask       (out_mask),
        .out_last       (out_last),
        .busy           (busy)
    );

    // ---------------- behavioural FIFO (registered read) ----------------
    logic [DW-1:0] fifo_mem [0:1023];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    logic          fifo_drop = 1'b0;

    assign fifo_empty_bar = (wr_ptr != rd_ptr);

    always @(posedge clk) begin
        if (fifo_re) begin
            fifo_data <= fifo_mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end else if (fifo_drop) begin
            rd_ptr <= wr_ptr;
        end
    end

    // ---------------- scoreboard and reference model ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic          mask;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    pos = 0;          // beats already queued in the current burst
    int    checks = 0;
    int    passed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fifo_mem[wr_ptr % 1024] = d;
        wr_ptr = wr_ptr + 1;
        sb.push_back(beat_t'{data: d, mask: 1'b0, last: (pos == BL - 1)});
        pos = (pos + 1) % BL;
    endtask

    task automatic expect_pads();
        while (pos != 0) begin
            sb.push_back(beat_t'{data: '0, mask: 1'b1, last: (pos == BL - 1)});
            pos = (pos + 1) % BL;
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain_left"}, sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_fifo_re"},   fifo_re,   0);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_out_data"},  out_data,  0);
        check({name, "_out_mask"},  out_mask,  0);
        check({name, "_out_last"},  out_last,  0);
        check({name, "_busy"},      busy,      0);
    endtask

    // ---------------- sink ready driver ----------------
    int ready_mode = 0;      // 0: always 1, 1: toggle, 2: random
    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom % 2);
            endcase
        end
    end

    // ---------------- read / transfer accounting ----------------
    int unsigned cyc = 0;
    int unsigned rd_total = 0;
    int unsigned data_xfers = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_total   <= 0;
            data_xfers <= 0;
        end else begin
            if (fifo_re) rd_total <= rd_total + 1;
            if (out_valid && out_ready && !out_mask) data_xfers <= data_xfers + 1;
        end
    end

    // ---------------- monitor ----------------
    int          xfer_cycles[$];
    int          beat_no = 0;
    initial begin
        logic          stall = 1'b0;
        logic [DW-1:0] stall_data = '0;
        logic          stall_mask = 1'b0;
        beat_t         e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data",  out_data,  stall_data);
                    check("hold_mask",  out_mask,  stall_mask);
                end
                if (busy) check("fetch_ahead_le2", (rd_total - data_xfers) <= 2, 1);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        beat_no++;
                        $display("beat %0d data=0x%04h mask=%0b last=%0b (exp 0x%04h/%0b/%0b)",
                                 beat_no, out_data, out_mask, out_last, e.data, e.mask, e.last);
                        check("beat_data", out_data, e.data);
                        check("beat_mask", out_mask, e.mask);
                        check("beat_last", out_last, e.last);
                        xfer_cycles.push_back(int'(cyc));
                        if (out_last && !out_mask) begin
                            // Nothing for the next burst may be fetched yet.
                            check("last_outstanding", rd_total - data_xfers, 1);
                            check("last_no_re", fifo_re, 0);
                        end
                    end
                end
                stall      = out_valid && !out_ready;
                stall_data = out_data;
                stall_mask = out_mask;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int saw;
        int waited;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_empty_busy", busy, 0);

        // 8 words 1..8, ready high: latency and back-to-back beats
        ready_mode = 0;
        @(posedge clk); #1;
        xfer_cycles.delete();
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        check("lat_T_re", fifo_re, 0);
        @(posedge clk); #1;
        check("lat_T1_re", fifo_re, 1);
        check("lat_T1_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_T2_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_T3_valid", out_valid, 1);
        drain(100, "s1");
        check("s1_beats", xfer_cycles.size(), 8);
        if (xfer_cycles.size() == 8) check("s1_back_to_back", xfer_cycles[7] - xfer_cycles[0], 7);
        repeat (2) @(posedge clk); #1;
        check("s1_idle", busy, 0);

        // 16 random words, ready toggling
        ready_mode = 1;
        for (int i = 0; i < 16; i++) push_word(DW'($urandom));
        drain(300, "s2");
        repeat (2) @(posedge clk); #1;
        check("s2_idle", busy, 0);

        // 3 words, stall without flush, then flush pads
        ready_mode = 0;
        push_word(16'h00A1);
        push_word(16'h00A2);
        push_word(16'h00A3);
        drain(100, "s3");
        repeat (10) @(posedge clk); #1;
        check("s3_stall_busy", busy, 1);
        check("s3_stall_valid", out_valid, 0);
        expect_pads();
        check("s3_pad_count", sb.size(), 5);
        flush = 1'b1;
        drain(100, "s3_pad");
        flush = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("s3_idle", busy, 0);

        // Flush with an empty FIFO has no effect
        flush = 1'b1;
        saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || fifo_re) saw = 1;
        end
        check("flush_empty_idle", saw, 0);
        flush = 1'b0;
        @(posedge clk); #1;

        // Reset after the 4th beat of a burst
        ready_mode = 0;
        for (int i = 0; i < 8; i++) push_word(DW'($urandom));
        waited = 0;
        while (sb.size() > 4 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("s5_reached_beat4", sb.size(), 4);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        pos = 0;
        fifo_drop = 1'b1;
        @(posedge clk); #1;
        fifo_drop = 1'b0;
        @(posedge clk); #1;
        check("midrst_fifo_dropped", fifo_empty_bar, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) push_word(DW'($urandom));
        check("post_rst_no_early_re", fifo_re, 0);
        @(posedge clk); #1;
        check("post_rst_busy", busy, 1);
        drain(100, "s5");
        repeat (2) @(posedge clk); #1;
        check("s5_idle", busy, 0);

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            ready_mode = int'($urandom_range(0, 2));
            n = int'($urandom_range(1, 20));
            for (int k = 0; k < n; k++) push_word(DW'($urandom));
            drain(500, "rnd");
            if (($urandom % 2) == 1) begin
                expect_pads();
                flush = 1'b1;
                drain(200, "rnd_pad");
                flush = 1'b0;
                repeat (2) @(posedge clk); #1;
                check("rnd_flush_idle", busy, 0);
            end else if (pos != 0) begin
                repeat (5) @(posedge clk); #1;
                check("rnd_stall_busy", busy, 1);
            end
        end

        // Close any partial burst left by the random rounds
        expect_pads();
        flush = 1'b1;
        drain(200, "final_pad");
        flush = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("final_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
